// File: rtl/scan_test_sequencer.sv
// scan_test_sequencer: full-scan test controller for one benchmark core.
// Accepts ATPG patterns over valid/ready and shifts each one into the core's
// scan chain. It then applies the PI vector, issues one capture cycle, and
// unloads the response. Unloaded bits and captured POs are compacted into a
// 16-bit MISR.
// All core-facing and status outputs are flops decoded from the next state,
// so there is no combinational path from po_in or scan_out to any output.
module scan_test_sequencer #(
  parameter int CHAIN_LEN = 21,
  parameter int PI_WIDTH  = 3,
  parameter int PO_WIDTH  = 6,
  parameter int CNT_W     = 16
) (
  input  logic                          CK,
  input  logic                          RSTN,
  input  logic                          start,
  input  logic                          abort,
  input  logic [CNT_W-1:0]              num_patterns,
  input  logic                          pat_valid,
  output logic                          pat_ready,
  input  logic [CHAIN_LEN+PI_WIDTH-1:0] pat_data,
  output logic                          scan_en,
  output logic                          scan_in,
  input  logic                          scan_out,
  output logic                          cut_ce,
  output logic [PI_WIDTH-1:0]           pi_out,
  input  logic [PO_WIDTH-1:0]           po_in,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   signature
);

  localparam int               BIT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [15:0]      MISR_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_WAIT = 3'd1,
    SHIFT     = 3'd2,
    CAPTURE   = 3'd3,
    UNLOAD    = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Sequencing state
  state_t               state_q,     state_d;
  logic [CHAIN_LEN-1:0] shreg_q,     shreg_d;
  logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]     pat_cnt_q,   pat_cnt_d;
  logic                 first_pat_q, first_pat_d;
  logic [15:0]          misr_q,      misr_d;
  logic [PI_WIDTH-1:0]  pi_q,        pi_d;

  // Registered output decode
  logic pat_ready_q, pat_ready_d;
  logic scan_en_q,   scan_en_d;
  logic scan_in_q,   scan_in_d;
  logic cut_ce_q,    cut_ce_d;
  logic busy_q,      busy_d;
  logic done_q,      done_d;

  logic [15:0] po_ext;
  logic [15:0] so_ext;

  // One MISR step: shift left, fold bit 15 back through the CCITT taps, add data.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] d);
    logic [15:0] fb;
    fb = sig[15] ? MISR_POLY : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ d;
  endfunction

  // Zero-extend the core's response bits to the MISR width.
  always_comb begin
    po_ext = '0;
    po_ext[PO_WIDTH-1:0] = po_in;
    so_ext = {15'b0, scan_out};
  end

  // Next-state, shift-register, counter and MISR update.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    first_pat_d = first_pat_q;
    misr_d      = misr_q;
    pi_d        = pi_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // abort in the same cycle as start keeps the session from starting
          if (start && !abort) begin
            misr_d      = 16'h0000;
            pat_cnt_d   = num_patterns;
            first_pat_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = (num_patterns != '0) ? LOAD_WAIT : DONE;
          end
        end

        LOAD_WAIT: begin
          if (pat_valid && pat_ready_q) begin
            shreg_d   = pat_data[CHAIN_LEN-1:0];
            pi_d      = pat_data[CHAIN_LEN +: PI_WIDTH];
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end

        SHIFT: begin
          shreg_d = shreg_q >> 1;
          // the first unload of a session is pre-test garbage, so it is masked
          if (!first_pat_q) begin
            misr_d = misr_next(misr_q, so_ext);
          end
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = CAPTURE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        CAPTURE: begin
          misr_d      = misr_next(misr_q, po_ext);
          first_pat_d = 1'b0;
          bit_cnt_d   = '0;
          if (pat_cnt_q != '0) begin
            pat_cnt_d = pat_cnt_q - CNT_W'(1);
          end
          state_d = (pat_cnt_q <= CNT_W'(1)) ? UNLOAD : LOAD_WAIT;
        end

        UNLOAD: begin
          misr_d = misr_next(misr_q, so_ext);
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output is a flop.
  always_comb begin
    pat_ready_d = (state_d == LOAD_WAIT);
    scan_en_d   = (state_d == SHIFT) || (state_d == UNLOAD);
    cut_ce_d    = (state_d == SHIFT) || (state_d == CAPTURE) || (state_d == UNLOAD);
    busy_d      = (state_d == LOAD_WAIT) || (state_d == SHIFT) ||
                  (state_d == CAPTURE)   || (state_d == UNLOAD);
    done_d      = (state_d == DONE);
    scan_in_d   = (state_d == SHIFT) ? shreg_d[0] : 1'b0;
  end

  // Sequencing state registers.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      pat_cnt_q   <= '0;
      first_pat_q <= 1'b0;
      misr_q      <= 16'h0000;
      pi_q        <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      first_pat_q <= first_pat_d;
      misr_q      <= misr_d;
      pi_q        <= pi_d;
    end
  end

  // Registered control outputs.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      pat_ready_q <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_in_q   <= 1'b0;
      cut_ce_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pat_ready_q <= pat_ready_d;
      scan_en_q   <= scan_en_d;
      scan_in_q   <= scan_in_d;
      cut_ce_q    <= cut_ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pat_ready = pat_ready_q;
  assign scan_en   = scan_en_q;
  assign scan_in   = scan_in_q;
  assign cut_ce    = cut_ce_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pi_out    = pi_q;
  assign signature = misr_q;

endmodule

// File: doc/scan_test_sequencer.md
Name: scan_test_sequencer

Overview:
Full-scan test controller for one sequential benchmark core (default: 21 flip-flops, 3 PIs, 6 POs) in the fault-simulation/ATPG test harness. It accepts ATPG patterns over a valid/ready port and shifts each pattern serially into the core's scan chain. It then applies the pattern's PI vector, issues one capture cycle, and unloads the response. Unloaded scan bits and captured POs are compacted into a 16-bit MISR signature for comparison against the fault-free value.

Parameters:
CHAIN_LEN, 21, scan-chain length (number of core flip-flops), >=2
PI_WIDTH, 3, core primary-input width
PO_WIDTH, 6, core primary-output width, <=16
CNT_W, 16, width of pattern counter

Ports:
CK  input  1  clock; the core is clocked by the same CK
RSTN  input  1  asynchronous active-low reset
start  input  1  begin session; sampled only in IDLE
abort  input  1  terminate session; return to IDLE
num_patterns  input  CNT_W  patterns in session; sampled with start
pat_valid  input  1  pattern word valid
pat_ready  output  1  sequencer accepts pattern word
pat_data  input  CHAIN_LEN+PI_WIDTH  [CHAIN_LEN-1:0] scan bits (bit 0 shifted first), upper bits = PI vector
scan_en  output  1  core scan-mode select
scan_in  output  1  serial data to chain head
scan_out  input  1  serial data from chain tail
cut_ce  output  1  core flip-flop clock enable
pi_out  output  PI_WIDTH  core primary inputs
po_in  input  PO_WIDTH  core primary outputs
busy  output  1  session in progress
done  output  1  one-cycle pulse at session end
signature  output  16  MISR value; stable outside busy

Behaviour:
- Reset: state=IDLE. All outputs 0, including signature and pat_ready. Internal shift register and counters are cleared.
- States: IDLE, LOAD_WAIT, SHIFT, CAPTURE, UNLOAD, DONE. The next-state and output decode is registered; no combinational path from po_in or scan_out to any output.
- IDLE: busy=0, cut_ce=0. A cycle with start=1 clears the MISR to 0x0000 and loads pat_cnt=num_patterns.
  - num_patterns!=0: go to LOAD_WAIT.
  - num_patterns==0: go to DONE.
  - start outside IDLE is ignored.
- LOAD_WAIT: pat_ready=1, scan_en=0, cut_ce=0, so the core is frozen and stalls are harmless. On pat_valid&pat_ready, latch pat_data, set pi_out from the PI field, clear bit_cnt, and go to SHIFT.
- SHIFT: runs exactly CHAIN_LEN cycles, then goes to CAPTURE.
  - scan_en=1, cut_ce=1, scan_in=shreg[0]; the shift register shifts right each cycle.
  - Each cycle the MISR absorbs scan_out at bit 0. During the first pattern of a session the MISR is held, because the unload is pre-test state.
- CAPTURE: exactly 1 cycle.
  - scan_en=0, cut_ce=1, pi_out held.
  - The MISR absorbs po_in zero-extended to 16 bits, sampled in this cycle before the capture edge.
  - pat_cnt decrements. If the result is 0, go to UNLOAD; otherwise go to LOAD_WAIT.
- UNLOAD: runs CHAIN_LEN cycles, then goes to DONE.
  - scan_en=1, cut_ce=1, scan_in=0; the MISR absorbs scan_out each cycle.
- DONE: done=1 and busy=0 for 1 cycle, then IDLE. signature holds until the next start.
- busy=1 in LOAD_WAIT, SHIFT, CAPTURE and UNLOAD.
- pi_out holds its last value in LOAD_WAIT and IDLE. It is cleared only by reset.
- MISR update: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ d.
- Timing with pat_valid held high: start sampled at cycle 0 gives the first SHIFT at cycle 2. Each pattern costs 23 cycles (LOAD_WAIT + CHAIN_LEN + CAPTURE). done asserts at cycle 1+23N+CHAIN_LEN (cycle 45 for N=1).
- Abort (any state except IDLE): next cycle is IDLE.
  - scan_en=0, cut_ce=0, pat_ready=0, no done pulse.
  - signature is left at its partial value; busy drops.
  - abort and start in the same IDLE cycle: abort wins and the session does not start.
- RSTN asserted mid-session: immediate return to reset values. No done pulse.
- pat_cnt wrap is impossible: the decrement happens only when pat_cnt>=1.

Test Plan:
- Reset/idle: RSTN low with random inputs -> all outputs 0. Release with start=0 -> outputs remain 0 for 10 cycles.
- Single pattern, pat_data[20:0]=21'h15A5A5, PI=3'b101, pat_valid held -> scan_in sequence LSB-first 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,1,0,1,0,1 in cycles 2-22; cut_ce=1/scan_en=0 at cycle 23; pi_out=3'b101 from cycle 2; done at cycle 45.
- Zero response: N=3, scan_out=0, po_in=0 -> signature=0x0000, done at cycle 1+69+21=91. num_patterns=0 -> done one cycle after start, signature=0x0000.
- Mask and compaction: N=1, scan_out tied 1, po_in=6'h00 -> signature equals 21 absorbed 1s (golden model), not 42. Repeat with po_in=6'h2A and scan_out=0 -> signature = 0x002A shifted 21 times through 0x1021 feedback (golden model).
- Backpressure: pat_valid low 7 cycles in LOAD_WAIT between patterns -> cut_ce=0 throughout; signature identical to the no-stall run; done delayed by exactly 7 cycles.
- Abort/reset: abort in SHIFT cycle 10 -> next cycle IDLE, scan_en=0, no done; new start runs cleanly. RSTN pulse during UNLOAD -> all outputs 0 immediately.
